// File: rtl/bus_pkg.sv
// Shared definitions for the tri-state bus driver: default widths and the
// contention comparison used by the readback monitor.
package bus_pkg;

    // Default bus width and contention-counter width.
    localparam int BUS_W_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 8;

    // Returns 1 when this instance is driving and the readback disagrees.
    // any_diff is the OR-reduction of (bus ^ driven). It is 1 for a differing
    // bit. It is X when a bit is X/Z, which also counts as a mismatch, giving
    // case-inequality semantics independent of the bus width.
    function automatic logic contention_mismatch(input logic drive,
                                                 input logic any_diff);
        return drive && (any_diff !== 1'b0);
    endfunction

endpackage

// File: rtl/bus_readback_monitor.sv
// Readback monitor: samples the resolved bus every cycle, compares it with
// the value this instance drives, and keeps a registered contention flag plus
// a saturating count of contention cycles.
module bus_readback_monitor
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus,
    input  logic [WIDTH-1:0] drv_data,
    input  logic             drv_en,
    output logic [WIDTH-1:0] bus_rd,
    output logic             contention,
    output logic [CNT_W-1:0] cont_cnt
);

    logic any_diff;
    logic mismatch;

    // A disabled instance never flags, whatever the bus shows.
    assign any_diff = |(bus ^ drv_data);
    assign mismatch = contention_mismatch(drv_en, any_diff);

    // Sample the net, register the per-cycle mismatch, count it with saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rd     <= '0;
            contention <= 1'b0;
            cont_cnt   <= '0;
        end else begin
            bus_rd     <= bus;
            contention <= mismatch;
            if (mismatch && (cont_cnt != {CNT_W{1'b1}})) begin
                cont_cnt <= cont_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_driver.sv
// Tri-state driver for a shared multi-drop bus. The drive is all bits or
// none: no per-bit enables and no partial Z. The bus port is declared inout
// so the readback monitor sees the resolved net rather than only the local
// drive.
module tristate_bus_driver
    import bus_pkg::*;
#(
    parameter int WIDTH      = BUS_W_DEFAULT,
    parameter bit REGISTERED = 1'b1,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    inout  tri   [WIDTH-1:0] out,
    output logic [WIDTH-1:0] bus_rd,
    output logic             driving,
    output logic             contention,
    output logic [CNT_W-1:0] cont_cnt
);

    logic [WIDTH-1:0] drv_data;
    logic             drv_en;

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] data_q;
            logic             en_q;

            // Ownership changes only on clock edges. The async reset drops
            // en_q at once, so the bus is released without a clock.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                    en_q   <= 1'b0;
                end else begin
                    data_q <= in;
                    en_q   <= en;
                end
            end

            assign drv_data = data_q;
            assign drv_en   = en_q;
        end else begin : g_comb
            // Zero-latency pass-through. Reset still forces release.
            assign drv_data = in;
            assign drv_en   = en & ~rst;
        end
    endgenerate

    assign out     = drv_en ? drv_data : {WIDTH{1'bz}};
    assign driving = drv_en;

    bus_readback_monitor #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mon (
        .clk        (clk),
        .rst        (rst),
        .bus        (out),
        .drv_data   (drv_data),
        .drv_en     (drv_en),
        .bus_rd     (bus_rd),
        .contention (contention),
        .cont_cnt   (cont_cnt)
    );

endmodule

// File: tb/tb_tristate_bus_driver.sv
// Directed bench for tristate_bus_driver. Each net has a pullup and a bench
// probe driver. A released net reads all ones, and reads all zeros when the
// probe drives zero; both together show every DUT on that net is high-Z.
`timescale 1ns/1ps
module tb_tristate_bus_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    tri [3:0]  net_a;
    tri [7:0]  net_b;
    tri [15:0] net_c;

    pullup (net_a);
    pullup (net_b);
    pullup (net_c);

    logic        pa_en, pb_en, pc_en;
    logic [3:0]  pa_val;
    logic [7:0]  pb_val;
    logic [15:0] pc_val;

    assign net_a = pa_en ? pa_val : 4'bzzzz;
    assign net_b = pb_en ? pb_val : 8'bzzzzzzzz;
    assign net_c = pc_en ? pc_val : 16'bzzzzzzzzzzzzzzzz;

    // Group A: four 4-bit registered drivers on net_a
    logic [3:0] a_in  [4];
    logic [3:0] a_en;
    logic [3:0] a_rd  [4];
    logic [3:0] a_drv;
    logic [3:0] a_cont;
    logic [7:0] a_cnt [4];

    for (genvar g = 0; g < 4; g++) begin : g_a
        tristate_bus_driver #(.WIDTH(4), .REGISTERED(1'b1), .CNT_W(8)) u_a (
            .clk(clk), .rst(rst), .in(a_in[g]), .en(a_en[g]), .out(net_a),
            .bus_rd(a_rd[g]), .driving(a_drv[g]), .contention(a_cont[g]),
            .cont_cnt(a_cnt[g]));
    end

    // Group B: two 8-bit registered drivers on net_b
    logic [7:0] b_in  [2];
    logic [1:0] b_en;
    logic [7:0] b_rd  [2];
    logic [1:0] b_drv;
    logic [1:0] b_cont;
    logic [7:0] b_cnt [2];

    for (genvar g = 0; g < 2; g++) begin : g_b
        tristate_bus_driver #(.WIDTH(8), .REGISTERED(1'b1), .CNT_W(8)) u_b (
            .clk(clk), .rst(rst), .in(b_in[g]), .en(b_en[g]), .out(net_b),
            .bus_rd(b_rd[g]), .driving(b_drv[g]), .contention(b_cont[g]),
            .cont_cnt(b_cnt[g]));
    end

    // Group C: one 16-bit combinational driver on net_c
    logic [15:0] c_in;
    logic        c_en;
    logic [15:0] c_rd;
    logic        c_drv;
    logic        c_cont;
    logic [7:0]  c_cnt;

    tristate_bus_driver #(.WIDTH(16), .REGISTERED(1'b0), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .in(c_in), .en(c_en), .out(net_c),
        .bus_rd(c_rd), .driving(c_drv), .contention(c_cont), .cont_cnt(c_cnt));

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Confirms a net is released by every driver: all ones from the pullup,
    // all zeros when the probe pulls it low.
    task automatic check_released_all(input string tag);
        check_val({tag, "_a_pull"}, 32'(net_a), 32'h0000_000F);
        check_val({tag, "_b_pull"}, 32'(net_b), 32'h0000_00FF);
        check_val({tag, "_c_pull"}, 32'(net_c), 32'h0000_FFFF);
        pa_en = 1'b1; pa_val = '0;
        pb_en = 1'b1; pb_val = '0;
        pc_en = 1'b1; pc_val = '0;
        #1;
        check_val({tag, "_a_probe0"}, 32'(net_a), 32'h0);
        check_val({tag, "_b_probe0"}, 32'(net_b), 32'h0);
        check_val({tag, "_c_probe0"}, 32'(net_c), 32'h0);
        pa_en = 1'b0; pb_en = 1'b0; pc_en = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pa_en = 1'b0; pb_en = 1'b0; pc_en = 1'b0;
        pa_val = '0;  pb_val = '0;  pc_val = '0;
        for (int i = 0; i < 4; i++) a_in[i] = '0;
        for (int i = 0; i < 2; i++) b_in[i] = '0;
        a_en = '0; b_en = '0; c_en = 1'b0; c_in = '0;
        #2;

        // Reset state
        check_val("rst_a_cnt0", 32'(a_cnt[0]), 32'h0);
        check_val("rst_a_drv", 32'(a_drv), 32'h0);
        check_val("rst_b_cont", 32'(b_cont), 32'h0);
        check_val("rst_a_rd0", 32'(a_rd[0]), 32'h0);
        check_released_all("rst");

        // Enable while in reset: bus must stay released across an edge
        a_en[0] = 1'b1; a_in[0] = 4'hA;
        c_en = 1'b1; c_in = 16'h1234;
        #1;
        check_val("rst_c_gated", 32'(net_c), 32'h0000_FFFF);
        check_val("rst_c_drv", 32'(c_drv), 32'h0);
        c_en = 1'b0;
        tick();
        check_val("rst_en_held_z", 32'(net_a), 32'h0000_000F);
        check_val("rst_en_cnt", 32'(a_cnt[0]), 32'h0);

        // Reset release: drive appears one edge later
        rst = 1'b0;
        #1;
        check_val("rel_before_edge", 32'(net_a), 32'h0000_000F);
        tick();
        check_val("rel_drive_A", 32'(net_a), 32'h0000_000A);
        check_val("rel_driving", 32'(a_drv[0]), 32'h1);

        // Reset mid-drive releases asynchronously
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rel_pull", 32'(net_a), 32'h0000_000F);
        check_val("async_rel_drv", 32'(a_drv[0]), 32'h0);
        pa_en = 1'b1; pa_val = 4'h0;
        #1;
        check_val("async_rel_probe0", 32'(net_a), 32'h0);
        pa_en = 1'b0;
        rst = 1'b0;
        tick();
        check_val("rel2_drive_A", 32'(net_a), 32'h0000_000A);
        tick();
        check_val("rel2_rd_A", 32'(a_rd[0]), 32'h0000_000A);
        check_val("rel2_no_cont", 32'(a_cont[0]), 32'h0);

        // Single-owner rotation every 2 us (200 cycles of 10 ns)
        for (int k = 0; k < 8; k++) begin
            int owner;
            logic [3:0] prev;
            owner = k % 4;
            prev  = (k == 0) ? 4'hA : 4'(k);
            a_en = 4'b0001 << owner;
            a_in[owner] = 4'(k + 1);
            #1;
            check_val($sformatf("rot%0d_latency", k), 32'(net_a), 32'(prev));
            tick();
            check_val($sformatf("rot%0d_net", k), 32'(net_a), 32'(k + 1));
            check_val($sformatf("rot%0d_drv", k), 32'(a_drv), 32'(4'b0001 << owner));
            repeat (199) tick();
            check_val($sformatf("rot%0d_cont", k), 32'(a_cont), 32'h0);
            check_val($sformatf("rot%0d_rd", k), 32'(a_rd[owner]), 32'(k + 1));
        end
        check_val("rot_cnt_a0", 32'(a_cnt[0]), 32'h0);
        check_val("rot_cnt_a3", 32'(a_cnt[3]), 32'h0);

        // Data change while enabled: new value next edge, no gap to Z
        a_en = 4'b0100; a_in[2] = 4'h3;
        tick();
        a_in[2] = 4'h5;
        #3;
        check_val("chg_hold_old", 32'(net_a), 32'h3);
        @(posedge clk);
        #0.1;
        check_val("chg_new_value", 32'(net_a), 32'h5);
        #0.9;
        a_en = '0;
        tick();
        check_val("release_a", 32'(net_a), 32'h0000_000F);

        // Collision of two 8-bit drivers
        b_in[0] = 8'h40; b_in[1] = 8'h0C; b_en = 2'b11;
        tick();
        check_val("col_settle_cont", 32'(b_cont), 32'h0);
        tick();
        check_val("col_cont_both", 32'(b_cont), 32'h3);
        check_val("col_cnt0_1", 32'(b_cnt[0]), 32'h1);
        check_val("col_cnt1_1", 32'(b_cnt[1]), 32'h1);
        tick();
        check_val("col_cnt0_2", 32'(b_cnt[0]), 32'h2);
        b_en = 2'b01;
        tick();
        check_val("col_last_cont", 32'(b_cont), 32'h3);
        check_val("col_last_cnt1", 32'(b_cnt[1]), 32'h3);
        tick();
        check_val("col_clear_cont", 32'(b_cont), 32'h0);
        check_val("col_keep_cnt0", 32'(b_cnt[0]), 32'h3);
        check_val("col_rd_40", 32'(b_rd[0]), 32'h40);

        // Disabled instance ignores a foreign collision on the bus
        pb_en = 1'b1; pb_val = 8'h81;
        tick();
        tick();
        check_val("probe_col_b0", 32'(b_cont[0]), 32'h1);
        check_val("probe_col_b1_off", 32'(b_cont[1]), 32'h0);
        check_val("probe_col_cnt1", 32'(b_cnt[1]), 32'h3);
        pb_en = 1'b0;

        // Saturation: hold a collision for 300 cycles
        b_en = 2'b11;
        repeat (300) tick();
        check_val("sat_cnt0", 32'(b_cnt[0]), 32'hFF);
        check_val("sat_cnt1", 32'(b_cnt[1]), 32'hFF);
        repeat (3) tick();
        check_val("sat_hold", 32'(b_cnt[0]), 32'hFF);
        b_en = 2'b00;
        repeat (2) tick();
        check_val("sat_cont_clr", 32'(b_cont), 32'h0);
        check_val("sat_cnt_sticky", 32'(b_cnt[1]), 32'hFF);

        // All released on 4-, 8- and 16-bit buses
        check_val("all_rel_drv_a", 32'(a_drv), 32'h0);
        check_val("all_rel_drv_b", 32'(b_drv), 32'h0);
        check_val("all_rel_drv_c", 32'(c_drv), 32'h0);
        check_val("all_rel_cont_a", 32'(a_cont), 32'h0);
        check_released_all("all_rel");

        // Combinational mode follows en without a clock edge
        c_in = 16'h0400; c_en = 1'b1;
        #1;
        check_val("comb_on", 32'(net_c), 32'h0400);
        check_val("comb_drv_on", 32'(c_drv), 32'h1);
        c_en = 1'b0;
        #1;
        check_val("comb_off_pull", 32'(net_c), 32'h0000_FFFF);
        pc_en = 1'b1; pc_val = 16'h0000;
        #1;
        check_val("comb_off_probe0", 32'(net_c), 32'h0);
        pc_en = 1'b0;
        c_en = 1'b1;
        tick();
        tick();
        check_val("comb_rd", 32'(c_rd), 32'h0400);
        check_val("comb_no_cont", 32'(c_cont), 32'h0);
        #1;
        rst = 1'b1;
        #1;
        check_val("comb_rst_z", 32'(net_c), 32'h0000_FFFF);
        check_val("comb_rst_cnt_b", 32'(b_cnt[0]), 32'h0);
        rst = 1'b0;
        #1;
        check_val("comb_rst_off", 32'(net_c), 32'h0400);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tristate_bus_driver.md
Name: tristate_bus_driver

Overview:
- Parameterizable tri-state driver for a shared multi-drop bus.
- Several instances connect their outputs to one resolved net. At most one should be enabled at a time; the others present high-Z.
- Data and enable are registered, so bus ownership changes only on clock edges.
- A readback monitor compares the resolved bus with the value this instance drives and flags contention.

Parameters:
- WIDTH, 4, bus width in bits. Instantiated at 4, 8 and 16; any value ≥1 is legal.
- REGISTERED, 1, 1 = drive from registered data/enable; 0 = combinational pass-through (out = en ? in : Z), still gated by reset.
- CNT_W, 8, width of the saturating contention counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  data to place on the bus.
- en  input  1  drive enable; 1 = drive, 0 = release (high-Z).
- out  output (tri, wired to shared net)  WIDTH  bus drive; high-Z on every bit when not driving.
- bus_rd  output  WIDTH  resolved bus value sampled each cycle.
- driving  output  1  1 while this instance actively drives out.
- contention  output  1  registered flag: the previous cycle's readback differed from the driven value.
- cont_cnt  output  CNT_W  saturating count of cycles with contention.

Behaviour:
- Reset (asynchronous, active-high):
  - data_q = 0, en_q = 0, so out = all-Z immediately, with no clock needed.
  - bus_rd = 0, driving = 0, contention = 0, cont_cnt = 0.
  - In REGISTERED = 0 mode, rst also forces out to Z combinationally.
- REGISTERED = 1:
  - On each rising edge, data_q <= in and en_q <= en.
  - out = en_q ? data_q : {WIDTH{Z}}. Latency is 1 cycle from en/in to bus.
  - driving = en_q.
- REGISTERED = 0:
  - out = (en & ~rst) ? in : Z, with zero latency.
  - driving = en & ~rst.
- The output is all-bits-or-nothing: no per-bit enable and no partial Z.
- Readback: on each rising edge, bus_rd <= the resolved value of the out net.
- Contention detection:
  - At each rising edge with driving = 1, compare the resolved net with the driven value. Any bit differing, or any bit X/Z in simulation, is a mismatch (case inequality).
  - contention <= mismatch when driving, else 0. It is registered and cleared the cycle after the mismatch stops; it is not sticky.
  - cont_cnt increments by 1 on each mismatch cycle and saturates at all-ones.
  - cont_cnt clears only on rst.
- Release: when en falls, out returns to Z one edge later (REGISTERED = 1). The driver never holds the bus beyond its enabled cycle.
- Simultaneous drivers:
  - Each enabled instance drives its value, and the net resolves per Verilog wired rules (differing bits become X).
  - Every enabled instance reports contention on the next edge.
- A disabled instance never reports contention, whatever the bus value.
- If in changes while en stays 1, the new value appears on the next edge with no glitch to Z.
- Reset mid-drive releases the bus asynchronously within the same timestep.

Decomposition:
- Shared package bus_pkg:
  - default bus width constant (4);
  - localparam for counter width;
  - a function for contention comparison (returns mismatch bit).
- One natural sub-module, bus_readback_monitor: samples the net, compares it with the driven value, and holds the contention flag and counter. Drive logic stays in the top module.

Test Plan:
- Reset release: assert rst with en = 1, in = 4'hA.
  - Required: out = 4'bZZZZ immediately, cont_cnt = 0.
  - After rst drops, out = 4'hA one edge later.
- Single-owner rotation: four WIDTH = 4 instances on one net, one-hot enables rotating every 2 µs, each in incrementing per step.
  - Required: net equals the enabled instance's registered value, and no contention on any instance.
- All released: all en = 0.
  - Required: net = all-Z on 4-, 8- and 16-bit buses; driving = 0 everywhere; contention = 0.
- Collision: two WIDTH = 8 instances enabled with 8'h40 and 8'h0C.
  - Required: both contention = 1 the edge after the bus settles, and cont_cnt increments per cycle.
  - After one is disabled, contention returns to 0 on the following edge.
- Saturation: hold a collision for 300 cycles with CNT_W = 8.
  - Required: cont_cnt = 8'hFF and stays there.
- Combinational mode: REGISTERED = 0, WIDTH = 16, toggle en with in = 16'h0400.
  - Required: out follows en with no clock edge; with en = 0, out = 16'hZZZZ.
